// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the arithmetic library: rounding-mode
// encodings, special-value constructors and a leading-zero counter. Values are
// built 64 bits wide and truncated by the caller to its packed width.
package fp_pkg;

  localparam logic [1:0] RND_RNE = 2'd0;
  localparam logic [1:0] RND_RTZ = 2'd1;
  localparam logic [1:0] RND_RUP = 2'd2;
  localparam logic [1:0] RND_RDN = 2'd3;

  function automatic int fp_bias(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_exp_ones(input int expo_w, input int mant_w);
    return ((64'd1 << expo_w) - 64'd1) << mant_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int expo_w, input int mant_w);
    return fp_exp_ones(expo_w, mant_w) | (64'd1 << (mant_w - 1));
  endfunction

  function automatic logic [63:0] fp_inf(input logic sgn, input int expo_w, input int mant_w);
    return ({63'd0, sgn} << (expo_w + mant_w)) | fp_exp_ones(expo_w, mant_w);
  endfunction

  function automatic logic [63:0] fp_max_finite(input logic sgn, input int expo_w, input int mant_w);
    return ({63'd0, sgn} << (expo_w + mant_w)) |
           (((64'd1 << expo_w) - 64'd2) << mant_w) |
           ((64'd1 << mant_w) - 64'd1);
  endfunction

  // Leading zeros of v[n-1:0]; returns n for an all-zero field.
  function automatic logic [6:0] fp_lzc(input logic [63:0] v, input int n);
    logic [6:0] lz;
    lz = 7'(n);
    for (int i = 0; i < 64; i++) begin
      if (i < n && v[i]) lz = 7'(n - 1 - i);
    end
    return lz;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Rounds a normalised significand with guard/round/sticky bits and packs the
// result, applying the mode-dependent overflow value. Subnormal inputs carry
// a clear hidden bit and an exponent of 1; they pack with exponent field 0.
module fp_round
  import fp_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                     sgn,
  input  logic [EXPO_W:0]          expo,
  input  logic [MANT_W:0]          sig,
  input  logic                     grd,
  input  logic                     rbt,
  input  logic                     stk,
  input  logic [1:0]               rnd,
  output logic [EXPO_W+MANT_W:0]   res
);

  localparam int W = 1 + EXPO_W + MANT_W;
  localparam logic [EXPO_W:0] EXP_OVF = {1'b0, {EXPO_W{1'b1}}};

  function automatic logic round_inc(input logic s, input logic lsb, input logic g,
                                     input logic r, input logic t, input logic [1:0] mode);
    logic inc;
    case (mode)
      RND_RNE: inc = g & (r | t | lsb);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = (g | r | t) & ~s;
      default: inc = (g | r | t) & s;
    endcase
    return inc;
  endfunction

  function automatic logic [W-1:0] ovf_value(input logic s, input logic [1:0] mode);
    logic to_inf;
    case (mode)
      RND_RNE: to_inf = 1'b1;
      RND_RTZ: to_inf = 1'b0;
      RND_RUP: to_inf = ~s;
      default: to_inf = s;
    endcase
    if (to_inf) return W'(fp_inf(s, EXPO_W, MANT_W));
    return W'(fp_max_finite(s, EXPO_W, MANT_W));
  endfunction

  logic                inc;
  logic [MANT_W+1:0]   sig_r;
  logic [MANT_W:0]     sig_f;
  logic [EXPO_W:0]     exp_r;

  // Increment, renormalise a rounding carry, then saturate or pack.
  always_comb begin
    inc   = round_inc(sgn, sig[0], grd, rbt, stk, rnd);
    sig_r = {1'b0, sig} + {{(MANT_W+1){1'b0}}, inc};
    if (sig_r[MANT_W+1]) begin
      sig_f = sig_r[MANT_W+1:1];
      exp_r = expo + (EXPO_W+1)'(1);
    end else begin
      sig_f = sig_r[MANT_W:0];
      exp_r = expo;
    end
    if (exp_r >= EXP_OVF) res = ovf_value(sgn, rnd);
    else res = {sgn, (sig_f[MANT_W] ? exp_r[EXPO_W-1:0] : {EXPO_W{1'b0}}), sig_f[MANT_W-1:0]};
  end

endmodule

// File: rtl/fp_add_top.sv
// Floating-point adder: combinational unpack, align, add, normalise and round,
// followed by a single output register (latency 1, one operation per cycle).
module fp_add_top
  import fp_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  b,
  input  logic [1:0]                       rnd,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  res
);

  localparam int W = SIGN_W + EXPO_W + MANT_W;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXPO_W, MANT_W));

  logic [W-1:0]        op_x, op_y;
  logic                sx, sy, eff_sub;
  logic [EXPO_W-1:0]   ex_raw, ey_raw, ex, ey, ediff;
  logic [MANT_W:0]     sig_x, sig_y;
  logic [MANT_W+3:0]   x_al, y_ext, y_mask, y_sh;
  logic [MANT_W+4:0]   sum;
  logic [6:0]          lz;
  int                  lim, sh;
  logic [MANT_W+3:0]   nsig;
  logic [EXPO_W:0]     nexp;
  logic                nsgn;
  logic                nan_a, nan_b, inf_a, inf_b;
  logic [W-1:0]        rounded, res_d, res_p1;

  // Order operands by magnitude, align the smaller one with sticky, add/subtract.
  always_comb begin
    if (a[W-2:0] >= b[W-2:0]) begin
      op_x = a;
      op_y = b;
    end else begin
      op_x = b;
      op_y = a;
    end
    sx      = op_x[W-1];
    sy      = op_y[W-1];
    ex_raw  = op_x[W-2:MANT_W];
    ey_raw  = op_y[W-2:MANT_W];
    ex      = (ex_raw == '0) ? EXPO_W'(1) : ex_raw;
    ey      = (ey_raw == '0) ? EXPO_W'(1) : ey_raw;
    sig_x   = {ex_raw != '0, op_x[MANT_W-1:0]};
    sig_y   = {ey_raw != '0, op_y[MANT_W-1:0]};
    ediff   = ex - ey;
    x_al    = {sig_x, 3'b000};
    y_ext   = {sig_y, 3'b000};
    y_mask  = ~({(MANT_W+4){1'b1}} << ediff);
    if (int'(ediff) >= MANT_W + 3)
      y_sh = {{(MANT_W+3){1'b0}}, |sig_y};
    else
      y_sh = (y_ext >> ediff) | {{(MANT_W+3){1'b0}}, |(y_ext & y_mask)};
    eff_sub = sx ^ sy;
    sum     = eff_sub ? ({1'b0, x_al} - {1'b0, y_sh}) : ({1'b0, x_al} + {1'b0, y_sh});
  end

  // Normalise: right by one on carry, else left with the shift clamped at exponent 1.
  always_comb begin
    lz  = fp_lzc(64'(sum[MANT_W+3:0]), MANT_W + 4);
    lim = int'(ex) - 1;
    sh  = (int'(lz) > lim) ? lim : int'(lz);
    if (sum[MANT_W+4]) begin
      nsig = {sum[MANT_W+4:2], sum[1] | sum[0]};
      nexp = {1'b0, ex} + (EXPO_W+1)'(1);
    end else begin
      nsig = sum[MANT_W+3:0] << sh;
      nexp = (EXPO_W+1)'(int'(ex) - sh);
    end
    // An exact zero from opposite signs is +0 except under round-down.
    if (sum == '0) nsgn = eff_sub ? (rnd == RND_RDN) : sx;
    else nsgn = sx;
  end

  fp_round #(
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_round (
    .sgn  (nsgn),
    .expo (nexp),
    .sig  (nsig[MANT_W+3:3]),
    .grd  (nsig[2]),
    .rbt  (nsig[1]),
    .stk  (nsig[0]),
    .rnd  (rnd),
    .res  (rounded)
  );

  // NaN and infinity operands override the arithmetic result.
  always_comb begin
    nan_a = (&a[W-2:MANT_W]) && (|a[MANT_W-1:0]);
    nan_b = (&b[W-2:MANT_W]) && (|b[MANT_W-1:0]);
    inf_a = (&a[W-2:MANT_W]) && !(|a[MANT_W-1:0]);
    inf_b = (&b[W-2:MANT_W]) && !(|b[MANT_W-1:0]);
    res_d = rounded;
    if (nan_a || nan_b || (inf_a && inf_b && (a[W-1] != b[W-1]))) res_d = QNAN;
    else if (inf_a) res_d = a;
    else if (inf_b) res_d = b;
  end

  // Output stage register; reset clears the result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_p1 <= '0;
    else res_p1 <= res_d;
  end

  assign res = res_p1;

endmodule

// File: tb/tb_fp_add_top.sv
// Bench for fp_add_top at fp32: directed cases plus randomised operands checked
// against an exact big-integer reference of IEEE addition.
module tb_fp_add_top;

  logic        clk;
  logic        rst;
  logic [31:0] a, b, res;
  logic [1:0]  rnd;
  int          n_cmp;
  int          n_err;

  fp_add_top #(
    .SIGN_W (1),
    .EXPO_W (8),
    .MANT_W (23)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .rnd (rnd),
    .res (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Exact sum as an integer multiple of 2^(emin-bias-23), then IEEE rounding.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] rm);
    logic         sxx, syy, sgn, inc;
    int           exx, eyy, emin, p, e, sh;
    logic [23:0]  mx, my;
    logic [299:0] ax, ay, s, q, rem, half;
    sxx = x[31];
    syy = y[31];
    exx = int'(x[30:23]);
    eyy = int'(y[30:23]);
    if ((exx == 255 && x[22:0] != 0) || (eyy == 255 && y[22:0] != 0) ||
        (exx == 255 && eyy == 255 && sxx != syy)) return 32'h7FC00000;
    if (exx == 255) return x;
    if (eyy == 255) return y;
    mx = {exx != 0, x[22:0]};
    my = {eyy != 0, y[22:0]};
    if (exx == 0) exx = 1;
    if (eyy == 0) eyy = 1;
    emin = (exx < eyy) ? exx : eyy;
    ax = 300'(mx) << (exx - emin);
    ay = 300'(my) << (eyy - emin);
    if (sxx == syy) begin
      s = ax + ay; sgn = sxx;
    end else if (ax >= ay) begin
      s = ax - ay; sgn = sxx;
    end else begin
      s = ay - ax; sgn = syy;
    end
    if (s == 0) return (sxx == syy) ? {sxx, 31'd0} : {rm == 2'd3, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    sh = p - 23;
    e  = emin + sh;
    if (e < 1) begin
      sh = 1 - emin;
      e  = 1;
    end
    if (sh <= 0) begin
      q = s << (-sh); rem = 0; half = 0;
    end else begin
      q = s >> sh;
      rem = s & ((300'(1) << sh) - 300'(1));
      half = 300'(1) << (sh - 1);
    end
    case (rm)
      2'd0:    inc = (rem > half) || (rem == half && rem != 0 && q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = (rem != 0) && !sgn;
      default: inc = (rem != 0) && sgn;
    endcase
    q = q + 300'(inc);
    if (q >= (300'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      case (rm)
        2'd0:    return {sgn, 8'hFF, 23'd0};
        2'd1:    return {sgn, 8'hFE, 23'h7FFFFF};
        2'd2:    return sgn ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
        default: return sgn ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
      endcase
    end
    return {sgn, (q[23] ? 8'(e) : 8'd0), q[22:0]};
  endfunction

  // Drive one operation after a falling edge, check it just after the next rising edge.
  task automatic drv(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [1:0] rm, input logic [31:0] exp);
    @(negedge clk);
    a = x;
    b = y;
    rnd = rm;
    @(posedge clk);
    #1;
    chk(tag, res, exp);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [1:0]  rm;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    a = '0;
    b = '0;
    rnd = 2'd0;
    #2 rst = 1'b1;
    #1 chk("reset_init", res, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    drv("warm_2p2", 32'h40000000, 32'h40000000, 2'd0, 32'h40800000);
    // Reset asserted mid-cycle with an operation in flight.
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h3F800000;
    #2 rst = 1'b1;
    #1 chk("rst_async", res, 32'h0);
    @(posedge clk);
    #1 chk("rst_inflight", res, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release", res, 32'h0);

    drv("one_plus_one", 32'h3F800000, 32'h3F800000, 2'd0, 32'h40000000);
    drv("cancel_rne",   32'h3F800000, 32'hBF800000, 2'd0, 32'h00000000);
    drv("cancel_rdn",   32'h3F800000, 32'hBF800000, 2'd3, 32'h80000000);
    drv("negzero_pair", 32'h80000000, 32'h80000000, 2'd0, 32'h80000000);
    drv("tie_rne",      32'h3F800000, 32'h33800000, 2'd0, 32'h3F800000);
    drv("tie_rup",      32'h3F800000, 32'h33800000, 2'd2, 32'h3F800001);
    drv("tie_rtz",      32'h3F800000, 32'h33800000, 2'd1, 32'h3F800000);
    drv("ovf_rne",      32'h7F7FFFFF, 32'h7F7FFFFF, 2'd0, 32'h7F800000);
    drv("ovf_rtz",      32'h7F7FFFFF, 32'h7F7FFFFF, 2'd1, 32'h7F7FFFFF);
    drv("ovf_rdn",      32'h7F7FFFFF, 32'h7F7FFFFF, 2'd3, 32'h7F7FFFFF);
    drv("ovf_neg_rup",  32'hFF7FFFFF, 32'hFF7FFFFF, 2'd2, 32'hFF7FFFFF);
    drv("inf_minus_inf", 32'h7F800000, 32'hFF800000, 2'd0, 32'h7FC00000);
    drv("nan_in",       32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000);
    drv("neg_inf",      32'hFF800000, 32'h3F800000, 2'd0, 32'hFF800000);
    drv("sub_tiny",     32'h00000001, 32'h00000001, 2'd0, 32'h00000002);
    drv("sub_promote",  32'h00400000, 32'h00400000, 2'd0, 32'h00800000);
    drv("far_sub_rtz",  32'h3F800000, 32'hA0000000, 2'd1, 32'h3F7FFFFF);

    for (int i = 0; i < 600; i++) begin
      x  = $urandom;
      y  = $urandom;
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        1: y[30:23] = x[30:23] ^ 8'($urandom_range(0, 3));
        2: begin
          x[30:23] = 8'd0;
          y[30:23] = 8'($urandom_range(0, 2));
        end
        3: y = {~x[31], x[30:0] ^ 31'($urandom_range(0, 255))};
        default: ;
      endcase
      drv($sformatf("rand%0d", i), x, y, rm, ref_add(x, y, rm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
